vx_flush_unit: RTL

Bank-side flush responder for a cache bank. Accepts flush requests from the core/cluster over a valid/ready handshake, waits for the bank pipeline to drain, then walks every line index and drives one tag-invalidate per cycle into the bank's tag store. It also performs the power-on invalidation sweep after reset. It returns a tagged completion response when the sweep finishes, and asserts `busy` to block new bank requests while flushing.

---
 rtl/vx_flush_unit_pkg.sv | 23 ++
 rtl/vx_flush_unit.sv | 82 ++++++++
 2 files changed

// File: rtl/vx_flush_unit_pkg.sv
// Shared cache-bank definitions: flush FSM state encoding and line-index sizing.
// Bank-level assertions import this package to reference flush_state_t.
package vx_flush_unit_pkg;

    typedef enum logic [2:0] {
        FLUSH_RST   = 3'd0,
        FLUSH_INIT  = 3'd1,
        FLUSH_IDLE  = 3'd2,
        FLUSH_DRAIN = 3'd3,
        FLUSH_INV   = 3'd4,
        FLUSH_RSP   = 3'd5
    } flush_state_t;

    // Number of lines held by one bank.
    function automatic int bank_lines(input int cache_size, input int line_size, input int num_banks);
        return cache_size / (line_size * num_banks);
    endfunction

    function automatic int line_select_bits(input int cache_size, input int line_size, input int num_banks);
        return $clog2(bank_lines(cache_size, line_size, num_banks));
    endfunction

endpackage

// File: rtl/vx_flush_unit.sv
// Bank-side flush responder: power-on invalidation sweep, then drain-and-invalidate
// on each tagged flush request, followed by a tagged completion response.
module vx_flush_unit
    import vx_flush_unit_pkg::*;
#(
    parameter int CACHE_SIZE      = 16384,
    parameter int CACHE_LINE_SIZE = 64,
    parameter int NUM_BANKS       = 1,
    parameter int TAG_WIDTH       = 4,
    localparam int LINES            = bank_lines(CACHE_SIZE, CACHE_LINE_SIZE, NUM_BANKS),
    localparam int LINE_SELECT_BITS = line_select_bits(CACHE_SIZE, CACHE_LINE_SIZE, NUM_BANKS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush_req_valid,
    input  logic [TAG_WIDTH-1:0]        flush_req_tag,
    output logic                        flush_req_ready,
    output logic                        flush_rsp_valid,
    output logic [TAG_WIDTH-1:0]        flush_rsp_tag,
    input  logic                        flush_rsp_ready,
    input  logic                        pipe_idle,
    input  logic                        tag_stall,
    output logic                        tag_inv_valid,
    output logic [LINE_SELECT_BITS-1:0] tag_inv_addr,
    output logic                        busy
);

    flush_state_t                state;
    flush_state_t                next_state;
    logic [LINE_SELECT_BITS-1:0] ctr;
    logic [TAG_WIDTH-1:0]        tag;

    logic sweeping;
    logic inv_fire;
    logic last_line;
    logic req_fire;

    // Fire/accept qualifiers are decoded from registered state; inputs only gate updates.
    assign sweeping  = (state == FLUSH_INIT) || (state == FLUSH_INV);
    assign inv_fire  = sweeping && !tag_stall;
    assign last_line = (ctr == LINE_SELECT_BITS'(LINES - 1));
    assign req_fire  = (state == FLUSH_IDLE) && flush_req_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FLUSH_RST;
            ctr   <= '0;
            tag   <= '0;
        end else begin
            state <= next_state;
            if (inv_fire) begin
                ctr <= ctr + LINE_SELECT_BITS'(1);
            end
            if (req_fire) begin
                tag <= flush_req_tag;
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            FLUSH_RST:   next_state = FLUSH_INIT;
            FLUSH_INIT:  if (inv_fire && last_line) next_state = FLUSH_IDLE;
            FLUSH_IDLE:  if (flush_req_valid) next_state = FLUSH_DRAIN;
            FLUSH_DRAIN: if (pipe_idle) next_state = FLUSH_INV;
            FLUSH_INV:   if (inv_fire && last_line) next_state = FLUSH_RSP;
            FLUSH_RSP:   if (flush_rsp_ready) next_state = FLUSH_IDLE;
            default:     next_state = FLUSH_RST;
        endcase
    end

    always_comb begin
        flush_req_ready = (state == FLUSH_IDLE);
        flush_rsp_valid = (state == FLUSH_RSP);
        flush_rsp_tag   = (state == FLUSH_RSP) ? tag : '0;
        tag_inv_valid   = sweeping;
        tag_inv_addr    = sweeping ? ctr : '0;
        busy            = (state != FLUSH_IDLE);
    end

endmodule
